risc16_boot_ctrl: RTL and testbench
===================================

# risc16_boot_ctrl

Boot/load controller for the risc16f core. Holds the core in reset, receives a program image as a byte stream (e.g. from a UART receiver), writes it word-by-word into instruction memory, verifies a checksum and then releases the core. Sits between the byte source, the instruction memory write port and the core's `rst` input.

## Interface

- `BASE_ADDR`, 16'h0000: byte address of the first loaded word; word i is written at BASE_ADDR + 2*i.
- `MAX_WORDS`, 16'd32768: largest accepted word count; larger headers are an error.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to (re)load; honoured in IDLE, RUN, ERR, ignored otherwise.
- `s_valid`  in  1  byte available on `s_data`.
- `s_data`  in  8  stream byte.
- `s_ready`  out  1  controller accepts a byte this cycle.
- `mem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `mem_addr`  out  16  byte address of the write.
- `mem_din`  out  16  word written.
- `core_rst`  out  1  active-high reset to the core; 1 = core held.
- `busy`  out  1  load in progress (LEN_HI..CSUM).
- `done`  out  1  one-cycle pulse on successful load.
- `err`  out  1  level; high while in ERR.

## Operation

- Image format: length N (2 bytes, high first), N words (2 bytes each, high first), 1 checksum byte = XOR of all 2N data bytes (length bytes excluded).
- A byte transfers on a cycle with `s_valid && s_ready`; no transfer otherwise, state holds.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, RUN, ERR.
- IDLE: `core_rst`=1, `s_ready`=0; `start` -> LEN_HI.
- LEN_HI: take byte into count[15:8] -> LEN_LO.
- LEN_LO: take count[7:0]; clear word index and checksum accumulator; if N > MAX_WORDS -> ERR; if N == 0 -> CSUM; else -> DATA_HI.
- DATA_HI: latch high byte, XOR into accumulator -> DATA_LO.
- DATA_LO: latch low byte, XOR into accumulator, schedule write of word index i; increment i; if i+1 == N -> CSUM, else -> DATA_HI.
- CSUM: take byte; equal to accumulator -> RUN with `done` pulse; else -> ERR.
- RUN: `core_rst`=0, `s_ready`=0; `start` -> LEN_HI with `core_rst` back to 1.
- ERR: `core_rst`=1, `s_ready`=0, `err`=1; `start` -> LEN_HI.
- `s_ready` = 1 exactly in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM.
- Address arithmetic: mem_addr = BASE_ADDR + {i[14:0],1'b0}, 16-bit, wraps modulo 2^16; no error on wrap.
- Word count and index are 16-bit unsigned.
- `start` asserted during a load is ignored; the load continues.

## Timing

- Reset (`rst`=0, asynchronous): state IDLE, `core_rst`=1, `s_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0, `busy`=0, `done`=0, `err`=0; all counters/accumulator 0.
- Deassertion of `rst` is synchronised internally; first active edge is the second `clk` rising edge after `rst` rises.
- `mem_we`, `mem_addr`, `mem_din` are registered: asserted the cycle after the DATA_LO handshake, for exactly one cycle; `mem_addr`/`mem_din` hold their last value otherwise.
- `start` in IDLE/RUN/ERR: `s_ready`=1 and `busy`=1 from the next cycle; in RUN, `core_rst` rises the same next cycle.
- Checksum handshake matches: next cycle `core_rst`=0, `done`=1 (one cycle), `busy`=0. The last word's `mem_we` occurs at least one cycle before `core_rst` falls.
- Mismatch or oversize length: next cycle `err`=1, `busy`=0, `core_rst` stays 1.
- Back-to-back bytes (s_valid held high): one byte per cycle, no bubbles; N-word image takes 2N+3 cycles from first byte to `core_rst` fall.
- `rst` asserted mid-load aborts immediately; memory already written is not restored.

## Test plan

- Reset then `start`; stream 00 02 12 34 AB CD 40 -> writes 16'h1234 @0x0000, 16'hABCD @0x0002; `done` pulse; `core_rst`=0 one cycle after checksum byte.
- Same image, checksum byte 41 -> no `done`, `err`=1, `core_rst`=1; then `start` and correct image -> RUN.
- Length 00 00, checksum 00 -> no `mem_we`, RUN; length 80 01 with MAX_WORDS=16'h8000 -> ERR after second length byte.
- BASE_ADDR=16'hFFFE, N=2 -> writes at 0xFFFE then 0x0000 (wrap).
- Random `s_valid` gaps on 8-word image -> identical writes/addresses as gap-free run; `start` pulses mid-load ignored.
- In RUN, pulse `start` -> `core_rst`=1 next cycle, reload works; assert `rst` low mid DATA_LO -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/risc16_boot_ctrl.sv
// Boot/load controller for risc16f: holds the core in reset, loads a byte-stream
// program image into instruction memory, verifies an XOR checksum, then releases the core.
module risc16_boot_ctrl #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0] MAX_WORDS = 16'd32768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_din,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, RUN, ERR
    } state_t;

    state_t      state, state_nxt;
    logic        rst_q;
    logic [15:0] count;
    logic [15:0] idx;
    logic [7:0]  acc;
    logic [7:0]  hi;

    logic        xfer;
    logic [15:0] len_word;
    logic [15:0] idx_inc;
    logic        load_nxt;

    // Assertion propagates asynchronously through rst_q; release is taken on the first edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_q <= 1'b0;
        else      rst_q <= 1'b1;
    end

    assign xfer     = s_valid && s_ready;
    assign len_word = {count[15:8], s_data};
    assign idx_inc  = idx + 16'd1;
    assign load_nxt = (state_nxt == LEN_HI) || (state_nxt == LEN_LO) ||
                      (state_nxt == DATA_HI) || (state_nxt == DATA_LO) ||
                      (state_nxt == CSUM);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RUN, ERR: if (start) state_nxt = LEN_HI;
            LEN_HI:  if (xfer) state_nxt = LEN_LO;
            LEN_LO:
                if (xfer) begin
                    if (len_word > MAX_WORDS)  state_nxt = ERR;
                    else if (len_word == 16'd0) state_nxt = CSUM;
                    else                       state_nxt = DATA_HI;
                end
            DATA_HI: if (xfer) state_nxt = DATA_LO;
            DATA_LO: if (xfer) state_nxt = (idx_inc == count) ? CSUM : DATA_HI;
            CSUM:    if (xfer) state_nxt = (s_data == acc) ? RUN : ERR;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they change with the state register.
    always_ff @(posedge clk or negedge rst_q) begin
        if (!rst_q) begin
            state    <= IDLE;
            count    <= 16'd0;
            idx      <= 16'd0;
            acc      <= 8'd0;
            hi       <= 8'd0;
            s_ready  <= 1'b0;
            busy     <= 1'b0;
            core_rst <= 1'b1;
            err      <= 1'b0;
            done     <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= 16'd0;
            mem_din  <= 16'd0;
        end else begin
            state    <= state_nxt;
            s_ready  <= load_nxt;
            busy     <= load_nxt;
            core_rst <= (state_nxt != RUN);
            err      <= (state_nxt == ERR);
            done     <= (state == CSUM) && xfer && (s_data == acc);
            mem_we   <= 1'b0;
            case (state)
                LEN_HI: if (xfer) count[15:8] <= s_data;
                LEN_LO:
                    if (xfer) begin
                        count[7:0] <= s_data;
                        idx        <= 16'd0;
                        acc        <= 8'd0;
                    end
                DATA_HI:
                    if (xfer) begin
                        hi  <= s_data;
                        acc <= acc ^ s_data;
                    end
                DATA_LO:
                    if (xfer) begin
                        acc      <= acc ^ s_data;
                        mem_we   <= 1'b1;
                        mem_addr <= BASE_ADDR + {idx[14:0], 1'b0};
                        mem_din  <= {hi, s_data};
                        idx      <= idx_inc;
                    end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_risc16_boot_ctrl.sv
// Self-checking bench: two controllers (base 0x0000 and 0xFFFE) share one byte stream;
// a byte-list reference model predicts writes, checksum outcome and status.
module tb_risc16_boot_ctrl;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic s_ready0, mem_we0, core_rst0, busy0, done0, err0;
    logic s_ready1, mem_we1, core_rst1, busy1, done1, err1;
    logic [15:0] mem_addr0, mem_din0, mem_addr1, mem_din1;

    always #5 clk = ~clk;

    risc16_boot_ctrl #(.BASE_ADDR(16'h0000), .MAX_WORDS(16'h8000)) dut0 (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_din(mem_din0),
        .core_rst(core_rst0), .busy(busy0), .done(done0), .err(err0));

    risc16_boot_ctrl #(.BASE_ADDR(16'hFFFE), .MAX_WORDS(16'h8000)) dut1 (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_din(mem_din1),
        .core_rst(core_rst1), .busy(busy1), .done(done1), .err(err1));

    int passed = 0, total = 0;
    int cyc = 0;
    int done_cnt0 = 0, done_cnt1 = 0;
    logic [31:0] wq0[$], wq1[$], exp0[$], exp1[$];
    logic [7:0]  img[$];
    bit          exp_ok;
    int          exp_nb, exp_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we0) wq0.push_back({mem_addr0, mem_din0});
        if (mem_we1) wq1.push_back({mem_addr1, mem_din1});
        if (done0) done_cnt0++;
        if (done1) done_cnt1++;
    end

    // Reference: interpret the image byte list directly.
    task automatic build_exp();
        logic [7:0]  x;
        logic [15:0] w, a;
        exp0.delete(); exp1.delete();
        exp_n = {24'd0, img[0]} * 256 + {24'd0, img[1]};
        x = 8'h00;
        if (exp_n > 32768) begin
            exp_ok = 1'b0;
            exp_nb = 2;
        end else begin
            for (int i = 0; i < exp_n; i++) begin
                w = {img[2 + 2*i], img[3 + 2*i]};
                x = x ^ img[2 + 2*i] ^ img[3 + 2*i];
                a = 16'(2 * i);
                exp0.push_back({a, w});
                a = 16'hFFFE + 16'(2 * i);
                exp1.push_back({a, w});
            end
            exp_ok = (img[2 + 2*exp_n] == x);
            exp_nb = 2 * exp_n + 3;
        end
    endtask

    task automatic run_image(input bit gaps, input bit pulses);
        int i = 0, guard = 0, t0 = -1;
        build_exp();
        wq0.delete(); wq1.delete();
        done_cnt0 = 0; done_cnt1 = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("start_sready", {s_ready0, s_ready1, busy0, busy1, core_rst0, core_rst1}, 6'b111111);
        while (i < exp_nb && guard < 5000) begin
            guard++;
            start = pulses && ($urandom_range(0, 3) == 0) && (i < exp_nb - 1);
            if (gaps && $urandom_range(0, 2) == 0) s_valid = 1'b0;
            else begin
                s_valid = 1'b1;
                s_data  = img[i];
                if (t0 < 0) t0 = cyc;
            end
            if (s_valid && s_ready0) i++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        start   = 1'b0;
        chk("bytes_taken", i, exp_nb);
        if (exp_ok) begin
            chk("end_run", {core_rst0, core_rst1, done0, done1, busy0}, 5'b00110);
            if (!gaps) chk("latency", cyc - t0, 2 * exp_n + 3);
        end else begin
            chk("end_err", {core_rst0, core_rst1, err0, err1, busy0}, 5'b11110);
        end
        repeat (2) @(negedge clk);
        chk("nw0", wq0.size(), exp0.size());
        for (int k = 0; k < exp0.size() && k < wq0.size(); k++) chk("wr0", wq0[k], exp0[k]);
        chk("nw1", wq1.size(), exp1.size());
        for (int k = 0; k < exp1.size() && k < wq1.size(); k++) chk("wr1", wq1[k], exp1[k]);
        chk("done_cnt", {done_cnt0[7:0], done_cnt1[7:0]}, exp_ok ? 16'h0101 : 16'h0000);
        chk("final", {err0, err1, core_rst0, core_rst1, s_ready0},
            exp_ok ? 5'b00000 : 5'b11110);
    endtask

    typedef struct {
        logic [55:0] b;
        int          len;
        bit          ok;
        int          nw;
        logic [15:0] last;
    } vec_t;

    vec_t tv[7];

    initial begin
        logic [31:0] lastw;
        logic [7:0]  x, r;
        tv[0] = '{56'h0002_1234_ABCD_40, 7, 1'b1, 2, 16'hABCD};
        tv[1] = '{56'h0002_1234_ABCD_41, 7, 1'b0, 2, 16'hABCD};
        tv[2] = '{56'h0002_1234_ABCD_40, 7, 1'b1, 2, 16'hABCD};
        tv[3] = '{56'h0000_0000_0000_00, 3, 1'b1, 0, 16'h0000};
        tv[4] = '{56'h8001_0000_0000_00, 2, 1'b0, 0, 16'h0000};
        tv[5] = '{56'h0001_FF00_FF00_00, 5, 1'b1, 1, 16'hFF00};
        tv[6] = '{56'h0000_0100_0000_00, 3, 1'b0, 0, 16'h0000};

        repeat (2) @(negedge clk);
        chk("rst_state", {s_ready0, mem_we0, core_rst0, busy0, done0, err0}, 6'b001000);
        chk("rst_bus", {mem_addr0, mem_din0}, 32'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle", {s_ready0, core_rst0, busy0, err0, s_ready1}, 5'b01000);

        for (int v = 0; v < 7; v++) begin
            img.delete();
            for (int k = 0; k < tv[v].len; k++) img.push_back(tv[v].b[55 - 8*k -: 8]);
            run_image(1'b0, 1'b0);
            chk("tv_nw", wq0.size(), tv[v].nw);
            chk("tv_done", done_cnt0, tv[v].ok ? 1 : 0);
            chk("tv_err", err0, !tv[v].ok);
            if (tv[v].nw > 0) begin
                lastw = wq0[wq0.size() - 1];
                chk("tv_last", lastw[15:0], tv[v].last);
            end
        end

        // Random 8-word images: gap-free, then the same image with gaps and start pulses.
        for (int r2 = 0; r2 < 4; r2++) begin
            img.delete();
            img.push_back(8'h00);
            img.push_back(8'h08);
            x = 8'h00;
            for (int k = 0; k < 16; k++) begin
                r = 8'($urandom);
                img.push_back(r);
                x = x ^ r;
            end
            img.push_back((r2 == 2) ? ~x : x);
            run_image(1'b0, 1'b0);
            run_image(1'b1, 1'b1);
        end

        // Reset asserted while waiting in DATA_LO.
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        s_valid = 1'b1;
        s_data = 8'h00; @(negedge clk);
        s_data = 8'h03; @(negedge clk);
        s_data = 8'hAA; @(negedge clk);
        s_data = 8'hBB;
        #2 rst = 1'b0;
        #1;
        chk("async_rst0", {s_ready0, mem_we0, core_rst0, busy0, done0, err0, mem_addr0, mem_din0},
            {6'b001000, 32'h0});
        chk("async_rst1", {s_ready1, mem_we1, core_rst1, busy1, done1, err1, mem_addr1, mem_din1},
            {6'b001000, 32'h0});
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        img.delete();
        for (int k = 0; k < 7; k++) img.push_back(tv[0].b[55 - 8*k -: 8]);
        run_image(1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
